// File: rtl/morse_sequencer_if.sv
// Control and status bundle between a host and the Morse sequencer; the host drives
// Start/Letter/Repeat and observes the tone output and the status pulses.
interface morse_sequencer_if;
    logic       Start;
    logic [4:0] Letter;
    logic       Repeat;
    logic       DotDashOut;
    logic       Busy;
    logic       Done;
    logic       Error;

    modport master (
        output Start, Letter, Repeat,
        input  DotDashOut, Busy, Done, Error
    );

    modport slave (
        input  Start, Letter, Repeat,
        output DotDashOut, Busy, Done, Error
    );
endinterface

// File: rtl/morse_sequencer.sv
// Morse A-Z playback sequencer: tone appears one clock after an accepted Start edge, slots last CLK_DIV clocks.
// No backpressure: Start edges while Busy are dropped; Done and Error are single-cycle pulses.
module morse_sequencer #(
    parameter int CLK_DIV = 250,
    parameter int PAT_W   = 16
) (
    input  logic              ClockIn,
    input  logic              Reset,
    morse_sequencer_if.slave  bus
);
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = $clog2(PAT_W);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t             state;
    logic               start_q;
    logic               armed_q;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [DIV_W-1:0]   div_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               dd_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [PAT_W-1:0]   rom_pat;
    logic [LEN_W-1:0]   rom_len;
    logic [IDX_W-1:0]   rom_idx;
    logic [IDX_W-1:0]   lat_idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic               start_edge;
    logic               letter_ok;

    // Patterns are MSB-first: bit L-1 is the first slot played.
    always_comb begin
        rom_pat = '0;
        rom_len = '0;
        case (bus.Letter)
            5'd0:  begin rom_pat = PAT_W'(5'b10111);          rom_len = LEN_W'(5);  end
            5'd1:  begin rom_pat = PAT_W'(9'b111010101);      rom_len = LEN_W'(9);  end
            5'd2:  begin rom_pat = PAT_W'(11'b11101011101);   rom_len = LEN_W'(11); end
            5'd3:  begin rom_pat = PAT_W'(7'b1110101);        rom_len = LEN_W'(7);  end
            5'd4:  begin rom_pat = PAT_W'(1'b1);              rom_len = LEN_W'(1);  end
            5'd5:  begin rom_pat = PAT_W'(9'b101011101);      rom_len = LEN_W'(9);  end
            5'd6:  begin rom_pat = PAT_W'(9'b111011101);      rom_len = LEN_W'(9);  end
            5'd7:  begin rom_pat = PAT_W'(7'b1010101);        rom_len = LEN_W'(7);  end
            5'd8:  begin rom_pat = PAT_W'(3'b101);            rom_len = LEN_W'(3);  end
            5'd9:  begin rom_pat = PAT_W'(13'b1011101110111); rom_len = LEN_W'(13); end
            5'd10: begin rom_pat = PAT_W'(9'b111010111);      rom_len = LEN_W'(9);  end
            5'd11: begin rom_pat = PAT_W'(9'b101110101);      rom_len = LEN_W'(9);  end
            5'd12: begin rom_pat = PAT_W'(7'b1110111);        rom_len = LEN_W'(7);  end
            5'd13: begin rom_pat = PAT_W'(5'b11101);          rom_len = LEN_W'(5);  end
            5'd14: begin rom_pat = PAT_W'(11'b11101110111);   rom_len = LEN_W'(11); end
            5'd15: begin rom_pat = PAT_W'(11'b10111011101);   rom_len = LEN_W'(11); end
            5'd16: begin rom_pat = PAT_W'(13'b1110111010111); rom_len = LEN_W'(13); end
            5'd17: begin rom_pat = PAT_W'(7'b1011101);        rom_len = LEN_W'(7);  end
            5'd18: begin rom_pat = PAT_W'(5'b10101);          rom_len = LEN_W'(5);  end
            5'd19: begin rom_pat = PAT_W'(3'b111);            rom_len = LEN_W'(3);  end
            5'd20: begin rom_pat = PAT_W'(7'b1010111);        rom_len = LEN_W'(7);  end
            5'd21: begin rom_pat = PAT_W'(9'b101010111);      rom_len = LEN_W'(9);  end
            5'd22: begin rom_pat = PAT_W'(9'b101110111);      rom_len = LEN_W'(9);  end
            5'd23: begin rom_pat = PAT_W'(11'b11101010111);   rom_len = LEN_W'(11); end
            5'd24: begin rom_pat = PAT_W'(13'b1110101110111); rom_len = LEN_W'(13); end
            5'd25: begin rom_pat = PAT_W'(11'b11101110101);   rom_len = LEN_W'(11); end
            default: begin rom_pat = '0;                      rom_len = '0;         end
        endcase
    end

    assign rom_idx    = IDX_W'(rom_len - LEN_W'(1));
    assign lat_idx    = IDX_W'(len_q - LEN_W'(1));
    assign nxt_idx    = IDX_W'(cnt_q - LEN_W'(1));
    assign letter_ok  = (bus.Letter <= 5'd25);
    // armed_q stays low until Start has been seen low after reset, so a level
    // held high through reset release never counts as an edge.
    assign start_edge = bus.Start & ~start_q & armed_q;

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= bus.Start;
            if (!bus.Start) armed_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (letter_ok) begin
                            pat_q  <= rom_pat;
                            len_q  <= rom_len;
                            div_q  <= DIV_RELOAD;
                            cnt_q  <= rom_len - LEN_W'(1);
                            dd_q   <= rom_pat[rom_idx];
                            busy_q <= 1'b1;
                            state  <= PLAY;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DIV_W'(1);
                    end else begin
                        div_q <= DIV_RELOAD;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - LEN_W'(1);
                            dd_q  <= pat_q[nxt_idx];
                        end else if (bus.Repeat) begin
                            cnt_q <= LEN_W'(2);
                            dd_q  <= 1'b0;
                            state <= GAP;
                        end else begin
                            dd_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DIV_W'(1);
                    end else begin
                        div_q <= DIV_RELOAD;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end else if (bus.Repeat) begin
                            cnt_q <= len_q - LEN_W'(1);
                            dd_q  <= pat_q[lat_idx];
                            state <= PLAY;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DotDashOut = dd_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Error      = err_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with CLK_DIV=4; outputs are sampled on the falling edge.
module tb_morse_sequencer;
    logic ClockIn;
    logic Reset;
    int   checks;
    int   errors;

    morse_sequencer_if bus();

    morse_sequencer #(.CLK_DIV(4), .PAT_W(16)) dut (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .bus     (bus)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic dd, input logic busy,
                              input logic done, input logic err);
        check({tag, " dd"},   bus.DotDashOut, dd);
        check({tag, " busy"}, bus.Busy,       busy);
        check({tag, " done"}, bus.Done,       done);
        check({tag, " err"},  bus.Error,      err);
    endtask

    // One-shot playback; the sample after the accepting edge is index 0.
    task automatic run_oneshot(input string tag, input logic [4:0] letter,
                               input logic [15:0] pat, input int len, input bit disturb);
        logic [15:0] p;
        int          n;
        logic        exp_dd;
        p = pat;
        n = len * 4;
        bus.Letter = letter;
        bus.Repeat = 1'b0;
        bus.Start  = 1'b1;
        for (int i = 0; i <= n + 1; i++) begin
            @(negedge ClockIn);
            exp_dd = (i < n) ? p[len - 1 - i / 4] : 1'b0;
            check_outs($sformatf("%s[%0d]", tag, i), exp_dd, (i < n), (i == n), 1'b0);
            if (!disturb && i == 1) bus.Start = 1'b0;
            if (disturb) begin
                case (i)
                    2:  bus.Start = 1'b0;
                    5:  begin bus.Start = 1'b1; bus.Letter = 5'd16; end
                    9:  bus.Letter = 5'd27;
                    12: bus.Start = 1'b0;
                    default: ;
                endcase
            end
        end
        bus.Start = 1'b0;
        @(negedge ClockIn);
    endtask

    initial begin
        logic exp_dd;
        checks     = 0;
        errors     = 0;
        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Letter = 5'd0;
        bus.Repeat = 1'b0;
        @(negedge ClockIn);
        @(negedge ClockIn);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        @(negedge ClockIn);

        // E one-shot: 4 cycles of tone, Done in the 5th
        run_oneshot("E", 5'd4, 16'b1, 1, 1'b0);

        // A one-shot with a second Start edge and Letter changes mid-playback
        run_oneshot("A", 5'd0, 16'b10111, 5, 1'b1);

        // Illegal letter: one-cycle Error, nothing else moves
        bus.Letter = 5'd27;
        bus.Start  = 1'b1;
        @(negedge ClockIn);
        check_outs("ill[0]", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge ClockIn);
        check_outs("ill[1]", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b0;
        @(negedge ClockIn);

        // T with repeat: 12 high, 12 low, 12 high; Repeat glitch in GAP is ignored
        bus.Letter = 5'd19;
        bus.Repeat = 1'b1;
        bus.Start  = 1'b1;
        for (int i = 0; i <= 37; i++) begin
            @(negedge ClockIn);
            exp_dd = (i < 12) || (i >= 24 && i < 36);
            check_outs($sformatf("T[%0d]", i), exp_dd, (i < 36), (i == 36), 1'b0);
            case (i)
                1:  bus.Start  = 1'b0;
                14: bus.Repeat = 1'b0;
                18: bus.Repeat = 1'b1;
                28: bus.Repeat = 1'b0;
                default: ;
            endcase
        end
        @(negedge ClockIn);

        // Q aborted by reset at cycle 7, then Start held high through release
        bus.Letter = 5'd16;
        bus.Repeat = 1'b0;
        bus.Start  = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge ClockIn);
            check_outs($sformatf("Q[%0d]", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        #2 Reset = 1'b1;
        #1 check_outs("Q async rst", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ClockIn);
            check_outs($sformatf("Q in rst[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ClockIn);
            check_outs($sformatf("held start[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.Start = 1'b0;
        @(negedge ClockIn);
        run_oneshot("E2", 5'd4, 16'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
